// File: rtl/bulls_cows_game_ctrl.sv
// Two-player Bulls and Cows sequencer: secret capture, alternating guesses, scoring and match score.
// Define BULLS_COWS_GUESS_LIMIT_EN to enable per-player guess limits ending a round in a draw.
module bulls_cows_game_ctrl #(
    parameter int RESULT_HOLD_CYCLES = 200000000,
    parameter int MAX_GUESSES        = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        confirm,
    output logic [2:0]  game_state,
    output logic [7:0]  J1_points,
    output logic [7:0]  J2_points,
    output logic [2:0]  bull_count,
    output logic [2:0]  cow_count,
    output logic        guess_confirmed,
    output logic        winner,
    output logic        input_error
);

    localparam int HOLD_W = (RESULT_HOLD_CYCLES > 1) ? $clog2(RESULT_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESULT_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } state_t;

    state_t            state_reg;
    logic [15:0]       secret1_reg;
    logic [15:0]       secret2_reg;
    logic [HOLD_W-1:0] hold_reg;

    logic [15:0] target;
    logic [3:0]  entry_digit  [4];
    logic [3:0]  target_digit [4];
    logic [3:0]  digit_in_range;
    logic [3:0]  bull_hit;
    logic [3:0]  present_hit;
    logic        entry_distinct;
    logic        entry_valid;
    logic [2:0]  bull_sum;
    logic [2:0]  present_sum;
    logic [2:0]  cow_sum;
    logic        in_guess;
    logic        score_fire;
    logic        new_round;
    logic        draw_now;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // J1 hunts secret2, J2 hunts secret1
    assign target = (state_reg == J1_GUESS) ? secret2_reg : secret1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign entry_digit[gi]    = sw[4*gi +: 4];
            assign target_digit[gi]   = target[4*gi +: 4];
            assign digit_in_range[gi] = (entry_digit[gi] <= 4'd9);
            assign bull_hit[gi]       = (entry_digit[gi] == target_digit[gi]);
            assign present_hit[gi]    = (entry_digit[gi] == target_digit[0]) |
                                        (entry_digit[gi] == target_digit[1]) |
                                        (entry_digit[gi] == target_digit[2]) |
                                        (entry_digit[gi] == target_digit[3]);
        end
    endgenerate

    assign entry_distinct = (entry_digit[0] != entry_digit[1]) && (entry_digit[0] != entry_digit[2]) &&
                            (entry_digit[0] != entry_digit[3]) && (entry_digit[1] != entry_digit[2]) &&
                            (entry_digit[1] != entry_digit[3]) && (entry_digit[2] != entry_digit[3]);
    assign entry_valid    = (&digit_in_range) && entry_distinct;

    // A bull is always also a present digit, so this never underflows
    assign bull_sum    = popcount4(bull_hit);
    assign present_sum = popcount4(present_hit);
    assign cow_sum     = present_sum - bull_sum;

    assign in_guess   = (state_reg == J1_GUESS) || (state_reg == J2_GUESS);
    assign score_fire = in_guess && !guess_confirmed && confirm && entry_valid;
    assign new_round  = (state_reg == END_GAME) && confirm;

`ifdef BULLS_COWS_GUESS_LIMIT_EN
    localparam int GC_W = (MAX_GUESSES > 0) ? $clog2(MAX_GUESSES + 1) : 1;
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(MAX_GUESSES);

    logic [GC_W-1:0] j1_guesses_reg;
    logic [GC_W-1:0] j2_guesses_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            j1_guesses_reg <= '0;
            j2_guesses_reg <= '0;
        end else if (new_round) begin
            j1_guesses_reg <= '0;
            j2_guesses_reg <= '0;
        end else if (score_fire) begin
            if (state_reg == J1_GUESS && j1_guesses_reg != GC_MAX)
                j1_guesses_reg <= j1_guesses_reg + 1'b1;
            if (state_reg == J2_GUESS && j2_guesses_reg != GC_MAX)
                j2_guesses_reg <= j2_guesses_reg + 1'b1;
        end
    end

    // The draw is only decided at the end of a J2 hold, once both players are exhausted
    assign draw_now = (state_reg == J2_GUESS) && (j1_guesses_reg == GC_MAX) && (j2_guesses_reg == GC_MAX);
`else
    // MAX_GUESSES has no effect without the guess limit
    assign draw_now = 1'b0 & (MAX_GUESSES == 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= J1_SETUP;
            secret1_reg     <= '0;
            secret2_reg     <= '0;
            hold_reg        <= '0;
            J1_points       <= '0;
            J2_points       <= '0;
            bull_count      <= '0;
            cow_count       <= '0;
            guess_confirmed <= 1'b0;
            winner          <= 1'b0;
            input_error     <= 1'b0;
        end else begin
            input_error <= 1'b0;
            case (state_reg)
                J1_SETUP: begin
                    if (confirm) begin
                        if (entry_valid) begin
                            secret1_reg <= sw;
                            state_reg   <= J2_SETUP;
                        end else begin
                            input_error <= 1'b1;
                        end
                    end
                end
                J2_SETUP: begin
                    if (confirm) begin
                        if (entry_valid) begin
                            secret2_reg <= sw;
                            state_reg   <= J1_GUESS;
                        end else begin
                            input_error <= 1'b1;
                        end
                    end
                end
                J1_GUESS, J2_GUESS: begin
                    if (guess_confirmed) begin
                        if (hold_reg == '0) begin
                            guess_confirmed <= 1'b0;
                            if (draw_now) begin
                                state_reg  <= END_GAME;
                                bull_count <= '0;
                                cow_count  <= '0;
                                winner     <= 1'b0;
                            end else begin
                                state_reg <= (state_reg == J1_GUESS) ? J2_GUESS : J1_GUESS;
                            end
                        end else begin
                            hold_reg <= hold_reg - 1'b1;
                        end
                    end else if (confirm) begin
                        if (!entry_valid) begin
                            input_error <= 1'b1;
                        end else begin
                            bull_count      <= bull_sum;
                            cow_count       <= cow_sum;
                            guess_confirmed <= 1'b1;
                            hold_reg        <= HOLD_LOAD;
                            if (bull_sum == 3'd4) begin
                                state_reg <= END_GAME;
                                winner    <= (state_reg == J2_GUESS);
                                if (state_reg == J1_GUESS) begin
                                    if (J1_points != 8'hFF) J1_points <= J1_points + 8'd1;
                                end else begin
                                    if (J2_points != 8'hFF) J2_points <= J2_points + 8'd1;
                                end
                            end
                        end
                    end
                end
                END_GAME: begin
                    guess_confirmed <= 1'b0;
                    if (confirm) begin
                        bull_count  <= '0;
                        cow_count   <= '0;
                        secret1_reg <= '0;
                        secret2_reg <= '0;
                        state_reg   <= J1_SETUP;
                    end
                end
                default: state_reg <= J1_SETUP;
            endcase
        end
    end

    assign game_state = state_reg;

endmodule
